// File: rtl/rv32i_types.sv
// Shared RV32 types: M-extension funct3 encodings and fixed divide corner-case results.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package rv32i_types;

    typedef enum logic [2:0] {
        MF_MUL    = 3'd0,
        MF_MULH   = 3'd1,
        MF_MULHSU = 3'd2,
        MF_MULHU  = 3'd3,
        MF_DIV    = 3'd4,
        MF_DIVU   = 3'd5,
        MF_REM    = 3'd6,
        MF_REMU   = 3'd7
    } muldiv_funct3_t;

    // Quotient returned for any divide by zero, and for the single signed overflow case.
    localparam logic [31:0] MULDIV_DIV0_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] MULDIV_OVF_Q  = 32'h8000_0000;

    // Two's complement negate of a 32-bit word.
    function automatic logic [31:0] neg32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// Unsigned iterative datapath: radix-2 shift-add multiply or restoring divide, one step per cycle.
// Latency: start loads operands; step 32 (counter==31) raises done_o with final values on the outputs.
// Backpressure: none; caller gates step_i and must capture results in the done_o cycle.
module muldiv_iter_core #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic              done_o,
    output logic [2*XLEN-1:0] prod_o,
    output logic [XLEN-1:0]   quot_o,
    output logic [XLEN-1:0]   rem_o
);

    // hi_q: upper product half / partial remainder; lo_q: multiplier / dividend shifting into quotient
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  b_q;
    logic [CNT_W-1:0] cnt_q;
    logic             div_q;

    logic [XLEN:0]    mul_sum;
    logic [XLEN:0]    rem_sh;
    logic [XLEN-1:0]  rem_diff;
    logic             rem_ge;

    // One multiply or divide step computed from the current registers.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        rem_sh   = {hi_q, lo_q[XLEN-1]};
        rem_ge   = (rem_sh >= {1'b0, b_q});
        // When rem_ge holds, the true difference is below b_q and fits in XLEN bits.
        rem_diff = rem_sh[XLEN-1:0] - b_q;
        if (div_q) begin
            hi_d = rem_ge ? rem_diff : rem_sh[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], rem_ge};
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        done_o = step_i && (cnt_q == CNT_W'(XLEN - 1));
        prod_o = {hi_d, lo_d};
        quot_o = lo_d;
        rem_o  = hi_d;
    end

    // Operand load on start, then advance one step per enabled cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (start_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            cnt_q <= '0;
            div_q <= is_div_i;
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide in EX: sign handling and FSM around an iterative unsigned core.
// Latency: 33 cycles accept-to-DONE (1 for div-by-zero/overflow, and for multiplies with MULDIV_FAST_MUL_EN).
// Backpressure: stall_o holds upstream until DONE; result held in DONE until advance_i.
module ex_muldiv_unit
    import rv32i_types::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            op_valid_i,
    input  logic [2:0]      op_funct3_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            flush_i,
    input  logic            advance_i,
    output logic            stall_o,
    output logic [XLEN-1:0] result_o,
    output logic            result_valid_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    muldiv_funct3_t  f3_q, f3_d;
    logic            neg_q, neg_d;     // product / quotient must be negated
    logic            rneg_q, rneg_d;   // remainder takes the (negative) dividend sign

    muldiv_funct3_t  f3;
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            is_div, div0, ovf, accept;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] mul_res, div_res;
    logic [63:0]     mul_fin;

    logic            core_start, core_step, core_done;
    logic [63:0]     core_prod;
    logic [XLEN-1:0] core_quot, core_rem;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a, fast_b;
    logic signed [63:0] fast_prod;
    logic [XLEN-1:0]    fast_res;

    // Single-cycle signed 33x33 product; the extra top bit carries per-operand signedness.
    always_comb begin
        fast_a    = $signed({a_sgn & rs1_i[XLEN-1], rs1_i});
        fast_b    = $signed({b_sgn & rs2_i[XLEN-1], rs2_i});
        fast_prod = 64'(fast_a) * 64'(fast_b);
        fast_res  = (f3 == MF_MUL) ? fast_prod[31:0] : fast_prod[63:32];
    end
`endif

    // Decode of the operation sitting in ID/EX: signedness, magnitudes and corner cases.
    always_comb begin
        f3     = muldiv_funct3_t'(op_funct3_i);
        a_sgn  = (f3 == MF_MULH) || (f3 == MF_MULHSU) || (f3 == MF_DIV) || (f3 == MF_REM);
        b_sgn  = (f3 == MF_MULH) || (f3 == MF_DIV) || (f3 == MF_REM);
        a_neg  = a_sgn && rs1_i[XLEN-1];
        b_neg  = b_sgn && rs2_i[XLEN-1];
        a_mag  = a_neg ? neg32(rs1_i) : rs1_i;
        b_mag  = b_neg ? neg32(rs2_i) : rs2_i;
        is_div = op_funct3_i[2];
        div0   = is_div && (rs2_i == '0);
        ovf    = ((f3 == MF_DIV) || (f3 == MF_REM)) &&
                 (rs1_i == MULDIV_OVF_Q) && (rs2_i == '1);
        // funct3[1] selects the remainder forms (REM/REMU).
        if (div0) begin
            special_res = op_funct3_i[1] ? rs1_i : MULDIV_DIV0_Q;
        end else begin
            special_res = op_funct3_i[1] ? '0 : MULDIV_OVF_Q;
        end
        accept = (state_q == ST_IDLE) && op_valid_i && !flush_i;
    end

    // Sign fix-up of the core's unsigned results using the flags latched at accept.
    always_comb begin
        mul_fin = neg_q ? (~core_prod + 64'd1) : core_prod;
        mul_res = (f3_q == MF_MUL) ? mul_fin[31:0] : mul_fin[63:32];
        if (f3_q[1]) begin
            div_res = rneg_q ? neg32(core_rem) : core_rem;
        end else begin
            div_res = neg_q ? neg32(core_quot) : core_quot;
        end
    end

    // Next state, result capture and core start; flush overrides everything.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        f3_d       = f3_q;
        neg_d      = neg_q;
        rneg_d     = rneg_q;
        core_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d   = f3;
                    neg_d  = a_neg ^ b_neg;
                    rneg_d = a_neg;
                    if (is_div && (div0 || ovf)) begin
                        state_d  = ST_DONE;
                        result_d = special_res;
                    end else if (is_div) begin
                        state_d    = ST_DIV;
                        core_start = 1'b1;
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d  = ST_DONE;
                        result_d = fast_res;
`else
                        state_d    = ST_MUL;
                        core_start = 1'b1;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (core_done) begin
                    state_d  = ST_DONE;
                    result_d = mul_res;
                end
            end
            ST_DIV: begin
                if (core_done) begin
                    state_d  = ST_DONE;
                    result_d = div_res;
                end
            end
            ST_DONE: begin
                if (advance_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush_i) begin
            state_d    = ST_IDLE;
            result_d   = result_q;
            core_start = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            f3_q     <= MF_MUL;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            f3_q     <= f3_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
        end
    end

    assign core_step      = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign stall_o        = op_valid_i && !flush_i && (state_q != ST_DONE);
    assign result_valid_o = (state_q == ST_DONE) && !flush_i;
    assign result_o       = result_q;

    muldiv_iter_core #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (core_start),
        .step_i   (core_step),
        .is_div_i (is_div),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .done_o   (core_done),
        .prod_o   (core_prod),
        .quot_o   (core_quot),
        .rem_o    (core_rem)
    );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: directed RV32M cases plus randomized ops against a transaction-level model.
// Latency: model predicts DONE cycle from accept cycle and op class.
// Backpressure: exercises advance_i holds, flushes, reset mid-op and back-to-back issue.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid_i = 1'b0;
    logic [2:0]  op_funct3_i = 3'd0;
    logic [31:0] rs1_i = 32'd0;
    logic [31:0] rs2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        advance_i = 1'b1;
    logic        stall_o;
    logic [31:0] result_o;
    logic        result_valid_o;

    int n_pass = 0;
    int n_total = 0;

    ex_muldiv_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .op_valid_i     (op_valid_i),
        .op_funct3_i    (op_funct3_i),
        .rs1_i          (rs1_i),
        .rs2_i          (rs2_i),
        .flush_i        (flush_i),
        .advance_i      (advance_i),
        .stall_o        (stall_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Architectural RV32M result computed with plain 64-bit / 32-bit arithmetic.
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        logic [31:0] r;
        bit          ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        ov = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r  = 32'd0;
        case (f)
            3'd0: begin p = ua * ub; r = p[31:0];  end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * ub; r = p[63:32]; end
            3'd3: begin p = ua * ub; r = p[63:32]; end
            3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ov ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: r = (b == 0) ? a : ov ? 32'd0 : 32'($signed(a) % $signed(b));
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Cycles from accept to the first DONE cycle.
    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return 33;
`endif
        end
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Transaction model: one op in flight, known accept cycle, known completion cycle.
    int          cyc = 0;
    bit          m_init = 0;
    bit          m_pend = 0;
    bit          m_clean = 1;
    int          m_done = 0;
    logic [31:0] m_exp = 32'd0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_init  = 1;
            m_pend  = 0;
            m_clean = 1;
        end else if (flush_i) begin
            m_pend = 0;
        end else if (m_pend) begin
            if (cyc >= m_done && advance_i) m_pend = 0;
        end else if (op_valid_i) begin
            m_pend = 1;
            m_done = cyc + ref_lat(op_funct3_i, rs1_i, rs2_i);
            m_exp  = ref_res(op_funct3_i, rs1_i, rs2_i);
        end
        cyc++;
        if (m_pend && cyc >= m_done) m_clean = 0;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        bit done_now;
        if (m_init) begin
            done_now = m_pend && (cyc >= m_done);
            check("stall_o", 32'(stall_o), 32'(op_valid_i && !flush_i && !done_now));
            check("result_valid_o", 32'(result_valid_o), 32'(done_now && !flush_i));
            if (done_now && !flush_i) check("result_o", result_o, m_exp);
            if (m_clean) check("result_o_cleared", result_o, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int k);
        op_valid_i  = 1'b0;
        op_funct3_i = 3'($urandom_range(0, 7));
        rs1_i       = $urandom;
        rs2_i       = $urandom;
        repeat (k) tick();
    endtask

    // Issue one op, wait for DONE (bounded), optionally hold it, then advance.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int flush_at, input bit use_lit, input logic [31:0] lit);
        int n;
        bit got;
        op_valid_i  = 1'b1;
        op_funct3_i = f;
        rs1_i       = a;
        rs2_i       = b;
        flush_i     = 1'b0;
        advance_i   = (hold == 0);
        n   = 0;
        got = 0;
        while (!got && n < 80) begin
            if (flush_at > 0 && n == flush_at) begin
                flush_i = 1'b1;
                @(negedge clk);
                check("flush_no_valid", 32'(result_valid_o), 32'd0);
                tick();
                flush_i    = 1'b0;
                op_valid_i = 1'b0;
                advance_i  = 1'b1;
                @(negedge clk);
                check("after_flush_valid", 32'(result_valid_o), 32'd0);
                tick();
                return;
            end
            @(negedge clk);
            if (result_valid_o) got = 1;
            else begin
                n++;
                tick();
            end
        end
        check("latency", 32'(n), 32'(ref_lat(f, a, b)));
        if (got && use_lit) check("literal_result", result_o, lit);
        repeat (hold) tick();
        if (hold > 0) begin
            @(negedge clk);
            check("held_stall", 32'(stall_o), 32'd0);
            if (use_lit) check("held_result", result_o, lit);
        end
        advance_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset: stall follows op_valid, no result.
        rst_n      = 1'b0;
        op_valid_i = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("reset_stall", 32'(stall_o), 32'd1);
        check("reset_valid", 32'(result_valid_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        tick();
        rst_n      = 1'b1;
        op_valid_i = 1'b0;

        // Hand-computed values pinning the reference model.
        check("ref_mul",    ref_res(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("ref_mulhu",  ref_res(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("ref_mulh",   ref_res(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
        check("ref_mulhsu", ref_res(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("ref_div",    ref_res(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("ref_rem",    ref_res(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
        check("ref_divu0",  ref_res(3'd5, 32'd7, 32'd0), 32'hFFFF_FFFF);
        check("ref_ovf_q",  ref_res(3'd4, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);

        // Directed cases.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 1, 32'hFFFF_FFEB);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFE);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'h0000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 32'hFFFF_FFFD);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd5, 32'd7, 32'd0, 0, 0, 1, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd7, 32'd0, 0, 0, 1, 32'd7);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'h8000_0000);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 1, 32'd0);
        idle(2);

        // DONE held by a downstream stall, then back-to-back multiply.
        run_op(3'd0, 32'd5, 32'd6, 5, 0, 1, 32'd30);
        run_op(3'd0, 32'd3, 32'd4, 0, 0, 1, 32'd12);

        // Non-M instructions do nothing.
        idle(3);

        // Flush at multiply cycle 10.
        run_op(3'd0, 32'd123, 32'd456, 0, 10, 0, 32'd0);
        idle(2);

        // Reset in the middle of a divide.
        op_valid_i  = 1'b1;
        op_funct3_i = 3'd4;
        rs1_i       = 32'd100;
        rs2_i       = 32'd7;
        repeat (15) tick();
        rst_n      = 1'b0;
        op_valid_i = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("midop_reset_result", result_o, 32'd0);
        check("midop_reset_valid", 32'(result_valid_o), 32'd0);
        tick();

        // Randomized traffic.
        repeat (60) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            int          fl;
            f  = 3'($urandom_range(0, 7));
            a  = pick();
            b  = pick();
            fl = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 30)) : 0;
            run_op(f, a, b, int'($urandom_range(0, 2)), fl, 0, 32'd0);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end

        idle(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- RV32M multiply/divide unit in the EX stage, fed directly by the ID/EX stage registers (decoded M-op flag, funct3, rs1/rs2 operand values).
- Iterative radix-2 multiplier and restoring divider.
- Asserts a stall that freezes ID/EX and all upstream stage registers until the result is ready.
- Holds the result until the pipeline advances into EX/MEM.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous active-low reset.
- op_valid_i  in  1  ID/EX holds a valid M-extension instruction (from control word).
- op_funct3_i  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- rs1_i  in  XLEN  operand A (post-forwarding).
- rs2_i  in  XLEN  operand B (post-forwarding).
- flush_i  in  1  branch/jump flush of the EX instruction.
- advance_i  in  1  EX/MEM register load enable this cycle.
- stall_o  out  1  hold ID/EX and upstream stage registers.
- result_o  out  XLEN  M-op result.
- result_valid_o  out  1  result_o valid for the instruction in EX.

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- Reset (rst_n=0 at posedge): state=IDLE; counter, result, and operand/accumulator registers=0. Outputs are then stall_o=op_valid_i&&!flush_i, result_o=0, result_valid_o=0.
- Reset mid-operation abandons the op with no result.
- stall_o is combinational: op_valid_i && !flush_i && state!=DONE.
- IDLE, on op_valid_i && !flush_i (accept):
  - Latch |rs1|, |rs2|, negate flags, and funct3; counter=0.
  - Signedness: MULH/DIV/REM treat both operands as signed; MULHSU treats rs1 only as signed; MULHU/DIVU/REMU/MUL treat both as unsigned magnitudes (MUL low word is sign-independent).
  - Next state is MUL for funct3[2]=0, DIV for funct3[2]=1.
  - Divide-by-zero (rs2=0) goes straight to DONE with the following results:
    - DIV/DIVU: 0xFFFFFFFF.
    - REM/REMU: rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF) goes straight to DONE with the following results:
    - DIV: 0x80000000.
    - REM: 0.
- MUL: one shift-add per cycle into a 64-bit accumulator. After 32 cycles (counter==31) go to DONE and register the final value:
  - Negate the 64-bit product if the signs differ.
  - MUL takes bits[31:0]; all other mul ops take bits[63:32].
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit). After 32 cycles go to DONE and register the final value:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
- Latency: op present in cycle N (IDLE) → states MUL/DIV in N+1..N+32 → DONE in N+33. Special cases reach DONE in N+1.
- DONE:
  - result_valid_o=1 and stall_o=0.
  - advance_i=1 → IDLE next cycle.
  - advance_i=0 (stall elsewhere, e.g. memory) → remain in DONE, result held, no restart.
- flush_i in any state → IDLE next cycle; result_valid_o=0 that cycle.
- Back-to-back M-ops: the DONE→IDLE edge loads the next op into ID/EX; it is accepted in the following cycle.
- Non-M instructions (op_valid_i=0) in IDLE: no effect, stall_o=0.

Optional Feature:
- MULDIV_FAST_MUL_EN defined: mul ops use a combinational 33x33 signed product. Accept goes IDLE→DONE directly with the registered result; latency is 1 cycle and state MUL is unused.
- Undefined: iterative 32-cycle multiply as above.
- Division is iterative in both cases.

Decomposition:
- rv32i_types gains:
  - muldiv_funct3_t enum (the 8 encodings above).
  - Constants MULDIV_DIV0_Q = 32'hFFFFFFFF and MULDIV_OVF_Q = 32'h80000000.
- FSM state enum stays local.
- One sub-module, muldiv_iter_core, holds the accumulator/remainder/counter datapath. It has a start/op/done interface; sign handling and the FSM stay in ex_muldiv_unit.

Test Plan:
- MUL rs1=7, rs2=-3: stall_o=1 for cycles N..N+32; result_valid_o at N+33 with result_o=0xFFFFFFEB.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULH same operands → 0x00000000; MULHSU -1×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 7/0 → 0xFFFFFFFF in 1 cycle; DIV 0x80000000/-1 → 0x80000000, REM → 0.
- DONE with advance_i=0 for 5 cycles → result held, stall_o=0, no restart; advance_i=1 → IDLE. Next back-to-back MUL 3×4 → 12.
- flush_i at MUL cycle 10 → IDLE next cycle, no result_valid_o; rst_n=0 mid-DIV → IDLE, result_o=0.
- With MULDIV_FAST_MUL_EN: MUL 7×-3 → result_valid_o at N+1, result_o=0xFFFFFFEB; DIV latency unchanged (33).
